// File: rtl/qspi_pkg.sv
// ----------------------------------------------------------------------------
// qspi_pkg : shared types and constants for the QSPI memory loader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR_HI = 3'd2,
    ADDR_LO = 3'd3,
    DATA    = 3'd4,
    IGNORE  = 3'd5
  } qspi_state_t;

  localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h02;
  localparam int         SYNC_STAGES       = 2;

endpackage

`default_nettype wire

// File: rtl/qspi_sync_edge.sv
// ----------------------------------------------------------------------------
// qspi_sync_edge : multi-flop synchroniser with rising/falling edge detect
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qspi_sync_edge
  import qspi_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

`default_nettype wire

// File: rtl/qspi_loader_ctrl.sv
// ----------------------------------------------------------------------------
// qspi_loader_ctrl : QSPI frame decoder issuing byte writes to a memory port.
// Optional QSPI_CHECKSUM_EN adds checksum_o and a zero-XOR frame check.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qspi_loader_ctrl
  import qspi_pkg::*;
#(
  parameter int         ADDR_WIDTH = 13,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] CMD_WRITE  = CMD_WRITE_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  qspi_sclk_i,
  input  logic                  qspi_cs_n_i,
  input  logic [3:0]            qspi_io_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           byte_count_o
`ifdef QSPI_CHECKSUM_EN
  ,output logic [7:0]           checksum_o
`endif
);

  logic w_sclk_unused_q, w_sclk_rise, w_sclk_unused_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic [3:0] w_io;

  qspi_sync_edge u_sclk_sync (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(qspi_sclk_i),
    .q_o(w_sclk_unused_q), .rise_o(w_sclk_rise), .fall_o(w_sclk_unused_fall)
  );

  qspi_sync_edge u_cs_sync (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(qspi_cs_n_i),
    .q_o(w_cs_q), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
  );

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_io_sync
    logic [SYNC_STAGES-1:0] io_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) io_q <= '0;
      else         io_q <= {io_q[SYNC_STAGES-2:0], qspi_io_i[gi]};
    end
    assign w_io[gi] = io_q[SYNC_STAGES-1];
  end

  qspi_state_t           state_q, state_d;
  logic                  phase_q, phase_d;
  logic [3:0]            hi_nib_q, hi_nib_d;
  logic [7:0]            addr_hi_q, addr_hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [15:0]           count_q, count_d;
  logic                  armed_q, armed_d;
`ifdef QSPI_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic       w_byte_valid;
  logic [7:0] w_byte;

  assign w_byte       = {hi_nib_q, w_io};
  assign w_byte_valid = w_sclk_rise && phase_q && (state_q != IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      hi_nib_q   <= '0;
      addr_hi_q  <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
      armed_q    <= 1'b0;
`ifdef QSPI_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hi_nib_q   <= hi_nib_d;
      addr_hi_q  <= addr_hi_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      count_q    <= count_d;
      armed_q    <= armed_d;
`ifdef QSPI_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hi_nib_d   = hi_nib_q;
    addr_hi_d  = addr_hi_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = 1'b0;
    error_d    = error_q;
    count_d    = count_q;
    armed_d    = armed_q | w_cs_q;
`ifdef QSPI_CHECKSUM_EN
    xor_d      = xor_q;
`endif

    // Address/count advance one cycle after each strobe.
    if (we_q) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end

    if (state_q != IDLE && w_sclk_rise) begin
      if (!phase_q) hi_nib_d = w_io;
      phase_d = ~phase_q;
    end

    case (state_q)
      IDLE: begin
        // armed_q blocks re-entry into a frame cut short by reset.
        if (w_cs_fall && armed_q) begin
          state_d = CMD;
          phase_d = 1'b0;
          count_d = '0;
          error_d = 1'b0;
`ifdef QSPI_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      CMD: if (w_byte_valid) begin
        if (w_byte == CMD_WRITE) begin
          state_d = ADDR_HI;
        end else begin
          state_d = IGNORE;
          error_d = 1'b1;
        end
      end
      ADDR_HI: if (w_byte_valid) begin
        addr_hi_d = w_byte;
        state_d   = ADDR_LO;
      end
      ADDR_LO: if (w_byte_valid) begin
        addr_d  = ADDR_WIDTH'({addr_hi_q, w_byte});
        state_d = DATA;
      end
      DATA: if (w_byte_valid) begin
        we_d       = 1'b1;
        mem_addr_d = addr_d;
        mem_data_d = DATA_WIDTH'(w_byte);
`ifdef QSPI_CHECKSUM_EN
        xor_d      = xor_q ^ w_byte;
`endif
      end
      default: ;
    endcase

    if (w_cs_rise && state_q != IDLE) begin
      state_d = IDLE;
      phase_d = 1'b0;
      case (state_q)
        CMD, ADDR_HI, ADDR_LO: error_d = 1'b1;
        DATA: begin
          done_d = 1'b1;
`ifdef QSPI_CHECKSUM_EN
          error_d = error_q | (xor_d != 8'h00);
`else
          error_d = error_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign mem_we_o     = we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign byte_count_o = count_q;
`ifdef QSPI_CHECKSUM_EN
  assign checksum_o   = xor_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qspi_loader_ctrl.sv
// ----------------------------------------------------------------------------
// tb_qspi_loader_ctrl : directed + randomized frames against a frame-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_qspi_loader_ctrl;

  localparam int AW = 13;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          qspi_sclk_i, qspi_cs_n_i;
  logic [3:0]    qspi_io_i;
  logic          mem_we_o, busy_o, done_o, error_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_data_o;
  logic [15:0]   byte_count_o;
`ifdef QSPI_CHECKSUM_EN
  logic [7:0]    checksum_o;
`endif

  qspi_loader_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .CMD_WRITE(8'h02)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .qspi_sclk_i(qspi_sclk_i), .qspi_cs_n_i(qspi_cs_n_i), .qspi_io_i(qspi_io_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .byte_count_o(byte_count_o)
`ifdef QSPI_CHECKSUM_EN
    ,.checksum_o(checksum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [7:0]      tx[$];
  logic [AW+7:0]   wr_q[$];
  logic [AW+7:0]   exp_wr[$];
  int              done_cnt;
  logic            exp_err, exp_done;
  int              exp_cnt;
  logic [7:0]      exp_xor;

  always @(negedge clk_i) begin
    if (mem_we_o) wr_q.push_back({mem_addr_o, mem_data_o});
    if (done_o)   done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_nibble(input logic [3:0] n);
    qspi_sclk_i = 1'b0;
    qspi_io_i   = n;
    tick(3);
    qspi_sclk_i = 1'b1;
    tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nibble(b[7:4]);
    send_nibble(b[3:0]);
  endtask

  task automatic cs_low();
    qspi_sclk_i = 1'b0;
    qspi_cs_n_i = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    qspi_sclk_i = 1'b0;
    tick(3);
    qspi_cs_n_i = 1'b1;
    tick(12);
  endtask

  // Frame-level expectation: what a well-behaved loader should do with tx.
  task automatic model();
    int a;
    exp_wr.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    exp_cnt  = 0;
    exp_xor  = 8'h00;
    if (tx.size() > 0 && tx[0] != 8'h02) begin
      exp_err = 1'b1;
    end else if (tx.size() < 3) begin
      exp_err = 1'b1;
    end else begin
      a = int'({tx[1], tx[2]}) % (1 << AW);
      for (int i = 3; i < tx.size(); i++) begin
        exp_wr.push_back({a[AW-1:0], tx[i]});
        a = (a + 1) % (1 << AW);
        exp_xor = exp_xor ^ tx[i];
        exp_cnt++;
      end
      exp_done = 1'b1;
`ifdef QSPI_CHECKSUM_EN
      exp_err = (exp_xor != 8'h00);
`endif
    end
  endtask

  task automatic run_frame(input string tag, input bit extra_nibble);
    wr_q.delete();
    done_cnt = 0;
    model();
    cs_low();
    check({tag, "_busy_in"}, 32'(busy_o), 32'd1);
    foreach (tx[i]) send_byte(tx[i]);
    if (extra_nibble) send_nibble(4'($urandom_range(0, 15)));
    check({tag, "_busy_pre"}, 32'(busy_o), 32'd1);
    cs_high();
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i])
      if (i < wr_q.size()) check({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_wr[i]));
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_err"}, 32'(error_o), 32'(exp_err));
    check({tag, "_cnt"}, 32'(byte_count_o), 32'(exp_cnt));
    check({tag, "_busy_post"}, 32'(busy_o), 32'd0);
`ifdef QSPI_CHECKSUM_EN
    check({tag, "_xor"}, 32'(checksum_o), 32'(exp_xor));
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},   32'(mem_we_o),     32'd0);
    check({tag, "_addr"}, 32'(mem_addr_o),   32'd0);
    check({tag, "_data"}, 32'(mem_data_o),   32'd0);
    check({tag, "_busy"}, 32'(busy_o),       32'd0);
    check({tag, "_done"}, 32'(done_o),       32'd0);
    check({tag, "_err"},  32'(error_o),      32'd0);
    check({tag, "_cnt"},  32'(byte_count_o), 32'd0);
  endtask

  initial begin
    reset_i     = 1'b1;
    qspi_sclk_i = 1'b0;
    qspi_cs_n_i = 1'b1;
    qspi_io_i   = 4'h0;
    tick(3);
    check_idle_outputs("reset");
    reset_i = 1'b0;
    tick(6);

    tx = '{8'h02, 8'h00, 8'h10, 8'hA5, 8'h3C};
    run_frame("basic", 1'b0);

    tx = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("badcmd", 1'b0);

    tx = '{8'h02, 8'hFF, 8'hFF, 8'h5A, 8'h6B, 8'h7C};
    run_frame("wrap", 1'b0);

    tx = '{8'h02, 8'h01, 8'h00, 8'hAA, 8'hBB};
    run_frame("partial", 1'b1);

    tx = '{8'h02, 8'h12};
    run_frame("short", 1'b0);

    // Reset while CS is held low in the middle of a payload.
    wr_q.delete();
    cs_low();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h11); send_byte(8'h22);
    tick(4);
    reset_i = 1'b1;
    #1;
    check_idle_outputs("midrst");
    tick(2);
    reset_i = 1'b0;
    wr_q.delete();
    send_byte(8'h33); send_byte(8'h44);
    tick(4);
    check("midrst_nowr", 32'(wr_q.size()), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    cs_high();
    check("midrst_nowr2", 32'(wr_q.size()), 32'd0);
    tx = '{8'h02, 8'h00, 8'h40, 8'hC3, 8'h3C};
    run_frame("postrst", 1'b0);

`ifdef QSPI_CHECKSUM_EN
    tx = '{8'h02, 8'h00, 8'h50, 8'h11, 8'h22, 8'h33};
    run_frame("csum_ok", 1'b0);
    tx = '{8'h02, 8'h00, 8'h60, 8'h11, 8'h22, 8'h34};
    run_frame("csum_bad", 1'b0);
`endif

    for (int f = 0; f < 8; f++) begin
      logic [7:0] cmd;
      int         len;
      cmd = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(3, 255))) : 8'h02;
      len = $urandom_range(1, 5);
      tx.delete();
      tx.push_back(cmd);
      tx.push_back(8'($urandom_range(0, 255)));
      tx.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < len; i++) tx.push_back(8'($urandom_range(0, 255)));
      run_frame("rand", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
